// File: rtl/adder_tree_pkg.sv
// Shared types and sizing helpers for the time-multiplexed adder-tree controller.
// Other files pull these in with import adder_tree_pkg::*.
package adder_tree_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    REDUCE = 2'd1,
    OUT    = 2'd2
  } state_t;

  function automatic int n_ops(input int levels);
    return 1 << levels;
  endfunction

  function automatic int res_w(input int adder_width, input int levels);
    return adder_width + levels;
  endfunction

  function automatic int slots(input int levels);
    return 2 * (1 << levels) - 1;
  endfunction

  // Counter width; never returns less than 1 so a counter always has a bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_tree_scratch.sv
// Scratch register file for the adder tree: operands in the low slots, partial
// sums above them. One write port, two operand read ports, one root read port.
module adder_tree_scratch
  import adder_tree_pkg::*;
#(
  parameter int SLOTS = 15,
  parameter int RW    = 35,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [RW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [RW-1:0] rdata_a,
  output logic [RW-1:0] rdata_b,
  output logic [RW-1:0] root
);

  logic [RW-1:0] mem [SLOTS];

  // NOTE: the storage array has no reset; every slot is written before it is
  // read in a job, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
  assign root    = mem[SLOTS-1];

endmodule

// File: rtl/adder_tree_seq_ctrl.sv
// Time-multiplexed adder-tree controller: loads 2**LEVELS operands, reduces them
// on one shared adder in tree order, then offers the sum. Optional perf counters
// under ADDER_TREE_SEQ_CTRL_PERF_EN.
module adder_tree_seq_ctrl
  import adder_tree_pkg::*;
#(
  parameter int ADDER_WIDTH = 32,
  parameter int LEVELS      = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDER_WIDTH-1:0]        in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDER_WIDTH+LEVELS-1:0] out_sum,
  output logic                          busy
`ifdef ADDER_TREE_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]                   job_count,
  output logic [31:0]                   stall_count
`endif
);

  localparam int N_OPS = n_ops(LEVELS);
  localparam int RES_W = res_w(ADDER_WIDTH, LEVELS);
  localparam int SLOTS = slots(LEVELS);
  localparam int BW    = clog2(N_OPS);
  localparam int AW    = clog2(SLOTS);

  localparam logic [BW-1:0] LAST_BEAT = BW'(N_OPS - 1);
  localparam logic [BW-1:0] LAST_STEP = BW'(N_OPS - 2);
  localparam logic [AW-1:0] SUM_BASE  = AW'(N_OPS);

  state_t state_q, state_d;
  logic [BW-1:0]    beat_q, step_q;
  logic             we;
  logic [AW-1:0]    waddr, raddr_a, raddr_b;
  logic [RES_W-1:0] wdata, rdata_a, rdata_b, root, add_sum;

  // Step s combines slots 2s and 2s+1, which is exactly tree order.
  assign raddr_a = AW'({step_q, 1'b0});
  assign raddr_b = AW'({step_q, 1'b1});
  assign add_sum = rdata_a + rdata_b;

  adder_tree_scratch #(
    .SLOTS (SLOTS),
    .RW    (RES_W),
    .AW    (AW)
  ) u_scratch (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .root    (root)
  );

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    we        = 1'b0;
    waddr     = AW'(beat_q);
    wdata     = RES_W'(in_data);
    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          we = 1'b1;
          if (beat_q == LAST_BEAT) state_d = REDUCE;
        end
      end
      REDUCE: begin
        busy  = 1'b1;
        we    = 1'b1;
        waddr = SUM_BASE + AW'(step_q);
        wdata = add_sum;
        if (step_q == LAST_STEP) state_d = OUT;
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  assign out_sum = (state_q == OUT) ? root : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      beat_q  <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == LOAD && in_valid) begin
        beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
      end
      step_q <= (state_q == REDUCE) ? step_q + 1'b1 : '0;
    end
  end

`ifdef ADDER_TREE_SEQ_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      job_count   <= '0;
      stall_count <= '0;
    end else begin
      if (out_valid && out_ready) job_count <= job_count + 1'b1;
      if (out_valid && !out_ready && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_tree_seq_ctrl.sv
// Directed self-checking bench for adder_tree_seq_ctrl (ADDER_WIDTH=32, LEVELS=3).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_adder_tree_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [34:0] out_sum;
  logic        busy;
`ifdef ADDER_TREE_SEQ_CTRL_PERF_EN
  logic [31:0] job_count;
  logic [31:0] stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adder_tree_seq_ctrl #(
    .ADDER_WIDTH (32),
    .LEVELS      (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .busy        (busy)
`ifdef ADDER_TREE_SEQ_CTRL_PERF_EN
    ,
    .job_count   (job_count),
    .stall_count (stall_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one beat; returns at the falling edge after it was accepted.
  task automatic send_beat(input logic [31:0] d);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("beat_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Eight beats base, base+inc, ...; gap bubble cycles after each beat but the last.
  task automatic load_job(input logic [31:0] base, input logic [31:0] inc, input int gap);
    for (int i = 0; i < 8; i++) begin
      send_beat(base + inc * i);
      if (i != 7) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) check("out_timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int cyc;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_sum", out_sum, 0);

    // 1..8 back-to-back: latency 7, sum 36, single-cycle out_valid.
    load_job(32'd1, 32'd1, 0);
    check("t1_busy_reduce", busy, 1);
    check("t1_in_ready_reduce", in_ready, 0);
    wait_out(cyc);
    check("t1_latency", cyc, 7);
    check("t1_sum", out_sum, 36);
    @(negedge clk);
    check("t1_valid_drop", out_valid, 0);
    check("t1_in_ready_back", in_ready, 1);

    // All-ones operands: full-width result with no truncation.
    load_job(32'hFFFF_FFFF, 32'd0, 0);
    wait_out(cyc);
    check("t2_sum_max", out_sum, 64'h7_FFFF_FFF8);
    @(negedge clk);

    // Output back-pressure for 5 cycles holds everything steady.
    out_ready = 1'b0;
    load_job(32'd5, 32'd5, 0);
    wait_out(cyc);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_sum", out_sum, 180);
      check("t3_hold_in_ready", in_ready, 0);
      check("t3_hold_busy", busy, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_release_in_ready", in_ready, 1);
    check("t3_release_valid", out_valid, 0);

    // Bubbles between beats do not advance the beat count.
    load_job(32'd10, 32'd10, 2);
    wait_out(cyc);
    check("t4_bubble_sum", out_sum, 360);
    @(negedge clk);

    // Reset mid-load discards the partial job.
    for (int i = 0; i < 5; i++) send_beat(32'd100 * (i + 1));
    do_reset();
    check("t5_rst_in_ready", in_ready, 1);
    check("t5_rst_busy", busy, 0);
    load_job(32'd2, 32'd0, 0);
    wait_out(cyc);
    check("t5_sum_after_rst", out_sum, 16);
    @(negedge clk);

    // Reset while the sum is waiting drops out_valid.
    out_ready = 1'b0;
    load_job(32'd3, 32'd0, 0);
    wait_out(cyc);
    check("t6_valid_before_rst", out_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_valid_after_rst", out_valid, 0);
    check("t6_sum_after_rst", out_sum, 0);
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t6_in_ready", in_ready, 1);

`ifdef ADDER_TREE_SEQ_CTRL_PERF_EN
    do_reset();
    check("p_job_rst", job_count, 0);
    check("p_stall_rst", stall_count, 0);
    load_job(32'd1, 32'd1, 0);
    wait_out(cyc);
    @(negedge clk);
    out_ready = 1'b0;
    load_job(32'd1, 32'd1, 0);
    wait_out(cyc);
    repeat (4) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    load_job(32'd1, 32'd1, 0);
    wait_out(cyc);
    @(negedge clk);
    check("p_job_count", job_count, 3);
    check("p_stall_count", stall_count, 4);
    do_reset();
    check("p_job_clear", job_count, 0);
    check("p_stall_clear", stall_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
